// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT section: widths, phase codes
// and the complex sample type used between stages.
package fft_pkg;

    localparam int DATA_W = 24;
    localparam int FRAC_W = 8;

    // Phase codes driven by the twiddle ROM alongside each sample
    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_BFLY    = 2'd1;
    localparam logic [1:0] ST_TWID    = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

endpackage

// File: rtl/cmul_q8.sv
// Combinational complex multiply by a fixed-point twiddle.
// Full-precision products, arithmetic shift by the twiddle fraction width
// (rounds toward -inf), then wrap to the sample width.
module cmul_q8 #(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 8
) (
    input  logic [DATA_W-1:0] h_r,
    input  logic [DATA_W-1:0] h_i,
    input  logic [DATA_W-1:0] w_r,
    input  logic [DATA_W-1:0] w_i,
    output logic [DATA_W-1:0] p_r,
    output logic [DATA_W-1:0] p_i
);

    logic signed [2*DATA_W-1:0] prod_rr;
    logic signed [2*DATA_W-1:0] prod_ii;
    logic signed [2*DATA_W-1:0] prod_ri;
    logic signed [2*DATA_W-1:0] prod_ir;
    logic signed [2*DATA_W:0]   sum_re;
    logic signed [2*DATA_W:0]   sum_im;

    // Operands are sign-extended to the product width before multiplying
    assign prod_rr = $signed(h_r) * $signed(w_r);
    assign prod_ii = $signed(h_i) * $signed(w_i);
    assign prod_ri = $signed(h_r) * $signed(w_i);
    assign prod_ir = $signed(h_i) * $signed(w_r);

    // One extra bit so the sum itself never overflows before scaling
    assign sum_re = prod_rr - prod_ii;
    assign sum_im = prod_ri + prod_ir;

    assign p_r = DATA_W'(sum_re >>> FRAC_W);
    assign p_i = DATA_W'(sum_im >>> FRAC_W);

endmodule

// File: rtl/r2sdf_bfly_stage_8.sv
// Radix-2 single-delay-feedback butterfly stage (16-point span).
// An 8-deep complex delay line feeds back the first half-frame; the ROM
// phase selects fill, butterfly (sum out / difference back) or twiddle
// multiply of the stored differences. One registered sample per accepted input.
module r2sdf_bfly_stage_8 #(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din_r,
    input  logic [DATA_W-1:0] din_i,
    input  logic [1:0]        state,
    input  logic [DATA_W-1:0] w_r,
    input  logic [DATA_W-1:0] w_i,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout_r,
    output logic [DATA_W-1:0] dout_i
);

    import fft_pkg::*;

    logic [DATA_W-1:0] dl_r_reg [DEPTH];
    logic [DATA_W-1:0] dl_i_reg [DEPTH];

    logic              out_valid_reg;
    logic [DATA_W-1:0] dout_r_reg;
    logic [DATA_W-1:0] dout_i_reg;

    logic              accept;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] head_i;
    logic [DATA_W-1:0] sum_r;
    logic [DATA_W-1:0] sum_i;
    logic [DATA_W-1:0] diff_r;
    logic [DATA_W-1:0] diff_i;
    logic [DATA_W-1:0] prod_r;
    logic [DATA_W-1:0] prod_i;
    logic [DATA_W-1:0] push_r;
    logic [DATA_W-1:0] push_i;

    // Illegal phase is treated like an idle cycle: nothing moves
    assign accept = in_valid && (state != ST_ILLEGAL);

    // Oldest entry sits at the far end of the shift chain
    assign head_r = dl_r_reg[DEPTH-1];
    assign head_i = dl_i_reg[DEPTH-1];

    // Plain modular add/sub: wraps at DATA_W bits, no scaling
    assign sum_r  = head_r + din_r;
    assign sum_i  = head_i + din_i;
    assign diff_r = head_r - din_r;
    assign diff_i = head_i - din_i;

    cmul_q8 #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_cmul (
        .h_r (head_r),
        .h_i (head_i),
        .w_r (w_r),
        .w_i (w_i),
        .p_r (prod_r),
        .p_i (prod_i)
    );

    // Butterfly feeds the difference back; fill and twiddle store the new sample
    always_comb begin
        push_r = din_r;
        push_i = din_i;
        if (state == ST_BFLY) begin
            push_r = diff_r;
            push_i = diff_i;
        end
    end

    // Delay line: tap 0 takes the pushed value, each later tap its neighbour
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dl
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        dl_r_reg[gi] <= '0;
                        dl_i_reg[gi] <= '0;
                    end else if (accept) begin
                        dl_r_reg[gi] <= push_r;
                        dl_i_reg[gi] <= push_i;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) begin
                        dl_r_reg[gi] <= '0;
                        dl_i_reg[gi] <= '0;
                    end else if (accept) begin
                        dl_r_reg[gi] <= dl_r_reg[gi-1];
                        dl_i_reg[gi] <= dl_i_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Output register: valid only in butterfly/twiddle phases, data holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            dout_r_reg    <= '0;
            dout_i_reg    <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            if (accept) begin
                if (state == ST_BFLY) begin
                    out_valid_reg <= 1'b1;
                    dout_r_reg    <= sum_r;
                    dout_i_reg    <= sum_i;
                end else if (state == ST_TWID) begin
                    out_valid_reg <= 1'b1;
                    dout_r_reg    <= prod_r;
                    dout_i_reg    <= prod_i;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign dout_r    = dout_r_reg;
    assign dout_i    = dout_i_reg;

endmodule

// File: tb/tb_r2sdf_bfly_stage_8.sv
// Self-checking bench for the radix-2 SDF butterfly stage. A queue-based
// reference model applies the phase rules with plain integer arithmetic.
module tb_r2sdf_bfly_stage_8;

    localparam int W = 24;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] din_r;
    logic [W-1:0] din_i;
    logic [1:0]   state;
    logic [W-1:0] w_r;
    logic [W-1:0] w_i;
    logic         out_valid;
    logic [W-1:0] dout_r;
    logic [W-1:0] dout_i;

    int checks   = 0;
    int failures = 0;

    // Reference model state: queue front is the oldest stored sample
    logic [W-1:0] q_r[$];
    logic [W-1:0] q_i[$];
    logic         exp_v;
    logic [W-1:0] exp_r;
    logic [W-1:0] exp_i;

    r2sdf_bfly_stage_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .state     (state),
        .w_r       (w_r),
        .w_i       (w_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sx(input logic [W-1:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [W-1:0] wrap(input longint x);
        return x[W-1:0];
    endfunction

    task automatic model_clear();
        q_r.delete();
        q_i.delete();
        for (int k = 0; k < 8; k++) begin
            q_r.push_back('0);
            q_i.push_back('0);
        end
        exp_v = 1'b0;
        exp_r = '0;
        exp_i = '0;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, exp_v});
        chk({tag, ".dout_r"}, dout_r, exp_r);
        chk({tag, ".dout_i"}, dout_i, exp_i);
        $display("%s v=%0d st=%0d din=(%0d,%0d) w=(%0d,%0d) -> ov=%0d dout=(%0d,%0d)",
                 tag, in_valid, state, $signed(din_r), $signed(din_i), $signed(w_r),
                 $signed(w_i), out_valid, $signed(dout_r), $signed(dout_i));
    endtask

    // Apply one input cycle, update the model, then check after the edge
    task automatic step(input string tag, input logic v, input logic [1:0] st,
                        input logic [W-1:0] dr, input logic [W-1:0] di,
                        input logic [W-1:0] wr, input logic [W-1:0] wi);
        logic [W-1:0] hr;
        logic [W-1:0] hi;
        longint       pr;
        longint       pi;
        in_valid = v;
        state    = st;
        din_r    = dr;
        din_i    = di;
        w_r      = wr;
        w_i      = wi;
        exp_v    = 1'b0;
        if (v && st != 2'd3) begin
            hr = q_r.pop_front();
            hi = q_i.pop_front();
            if (st == 2'd0) begin
                q_r.push_back(dr);
                q_i.push_back(di);
            end else if (st == 2'd1) begin
                exp_v = 1'b1;
                exp_r = wrap(sx(hr) + sx(dr));
                exp_i = wrap(sx(hi) + sx(di));
                q_r.push_back(wrap(sx(hr) - sx(dr)));
                q_i.push_back(wrap(sx(hi) - sx(di)));
            end else begin
                exp_v = 1'b1;
                pr = (sx(hr) * sx(wr) - sx(hi) * sx(wi)) >>> 8;
                pi = (sx(hr) * sx(wi) + sx(hi) * sx(wr)) >>> 8;
                exp_r = wrap(pr);
                exp_i = wrap(pi);
                q_r.push_back(dr);
                q_i.push_back(di);
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            rst      = 1'b1;
            in_valid = 1'b1;
            state    = 2'($urandom_range(0, 2));
            din_r    = W'($urandom);
            din_i    = W'($urandom);
            w_r      = W'($urandom);
            w_i      = W'($urandom);
            model_clear();
            @(posedge clk);
            #1;
            check_outputs("reset");
        end
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_w();
        return wrap(longint'($urandom_range(0, 512)) - 256);
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        state    = 2'd0;
        din_r    = '0;
        din_i    = '0;
        w_r      = '0;
        w_i      = '0;
        model_clear();

        // Reset with live input, then zeroed delay line seen through a butterfly
        reset_cycles(2);
        step("bfly_after_reset", 1'b1, 2'd1, 24'd5, 24'd0, '0, '0);
        chk("bfly_after_reset.const_r", dout_r, 24'd5);

        // Fill then butterfly with a ramp
        reset_cycles(1);
        for (int n = 0; n < 8; n++)
            step("fill", 1'b1, 2'd0, W'(256 * n), '0, '0, '0);
        for (int n = 8; n < 16; n++)
            step("bfly_ramp", 1'b1, 2'd1, W'(256 * n), '0, '0, '0);
        chk("bfly_ramp.last_r", dout_r, 24'd5632);

        // Twiddle pass by unity: stored differences come out unchanged
        for (int n = 0; n < 8; n++)
            step("twid_unity", 1'b1, 2'd2, W'($urandom), W'($urandom), 24'd256, 24'd0);
        chk("twid_unity.const_r", dout_r, 24'hFFF800);

        // Twiddle by -j and by a 45-degree factor
        reset_cycles(1);
        step("fill_j", 1'b1, 2'd0, 24'd256, 24'd0, '0, '0);
        step("fill_j", 1'b1, 2'd0, 24'd100, 24'd3, '0, '0);
        for (int n = 2; n < 8; n++)
            step("fill_j", 1'b1, 2'd0, W'($urandom), W'($urandom), '0, '0);
        step("twid_mj", 1'b1, 2'd2, '0, '0, 24'd0, wrap(-256));
        chk("twid_mj.const_i", dout_i, wrap(-256));
        step("twid_45", 1'b1, 2'd2, '0, '0, 24'd181, wrap(-181));
        chk("twid_45.const_r", dout_r, 24'd72);
        chk("twid_45.const_i", dout_i, wrap(-69));

        // Overflow wraps in the butterfly sum
        reset_cycles(1);
        step("fill_ovf", 1'b1, 2'd0, 24'h7FFFFF, 24'd0, '0, '0);
        for (int n = 1; n < 8; n++)
            step("fill_ovf", 1'b1, 2'd0, W'($urandom), W'($urandom), '0, '0);
        step("bfly_ovf", 1'b1, 2'd1, 24'd1, 24'd0, '0, '0);
        chk("bfly_ovf.const_r", dout_r, 24'h800000);

        // Mid-frame reset discards everything stored so far
        reset_cycles(1);
        for (int n = 0; n < 4; n++)
            step("fill_mid", 1'b1, 2'd0, W'($urandom), W'($urandom), '0, '0);
        reset_cycles(1);
        step("bfly_post_rst", 1'b1, 2'd1, 24'd7, 24'd7, '0, '0);
        chk("bfly_post_rst.const_i", dout_i, 24'd7);

        // Random streaming with idle gaps and illegal-phase cycles
        reset_cycles(1);
        for (int n = 0; n < 8; n++)
            step("rnd_fill", 1'b1, 2'd0, W'($urandom), W'($urandom), '0, '0);
        for (int f = 0; f < 6; f++) begin
            for (int ph = 1; ph <= 2; ph++) begin
                for (int n = 0; n < 8; n++) begin
                    while ($urandom_range(0, 4) == 0) begin
                        if ($urandom_range(0, 1) == 0)
                            step("rnd_gap", 1'b0, 2'(ph), W'($urandom), W'($urandom), rnd_w(), rnd_w());
                        else
                            step("rnd_ill", 1'b1, 2'd3, W'($urandom), W'($urandom), rnd_w(), rnd_w());
                    end
                    step("rnd_run", 1'b1, 2'(ph), W'($urandom), W'($urandom), rnd_w(), rnd_w());
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
